// File: rtl/demod_demapper_if.sv
// Symbol-in / bit-out bus of the hard-decision demapper.
// Handshake: a symbol transfers on a rising clock edge where EN_Demod,
// Valid_Demod_IN and Ready_Demod are all high. Ready_Demod does not depend
// on Valid_Demod_IN or EN_Demod, and the source holds its data until it
// transfers.
interface demod_demapper_if #(
   parameter int LUT_WIDTH = 18
);
   logic                        EN_Demod;
   logic                        Valid_Demod_IN;
   logic signed [LUT_WIDTH-1:0] Demod_IN_I;
   logic signed [LUT_WIDTH-1:0] Demod_IN_Q;
   logic                        Last_IN;
   logic [2:0]                  Order_Mod;
   logic                        Ready_Demod;
   logic                        Serial_OUT;
   logic                        Serial_Valid;
   logic                        Last_OUT;
   logic                        DEMOD_DONE;
   logic                        Order_Err;
   logic [10:0]                 Sym_Count;
   logic [0:0]                  State_Dbg;

   modport master (
      output EN_Demod, Valid_Demod_IN, Demod_IN_I, Demod_IN_Q, Last_IN, Order_Mod,
      input  Ready_Demod, Serial_OUT, Serial_Valid, Last_OUT, DEMOD_DONE,
             Order_Err, Sym_Count, State_Dbg
   );

   modport slave (
      input  EN_Demod, Valid_Demod_IN, Demod_IN_I, Demod_IN_Q, Last_IN, Order_Mod,
      output Ready_Demod, Serial_OUT, Serial_Valid, Last_OUT, DEMOD_DONE,
             Order_Err, Sym_Count, State_Dbg
   );
endinterface

// File: rtl/demod_demapper.sv
// Hard-decision QPSK/16QAM/64QAM demapper (38.211 Gray mapping).
// One I/Q symbol is sliced into up to six bits b0..b5 at the accept edge,
// then the bits leave serially, b0 first, one per enabled clock.
module demod_demapper #(
   parameter int LUT_WIDTH = 18,
   parameter int THR_16    = 41449,
   parameter int THR_64_2  = 20225,
   parameter int THR_64_4  = 40450,
   parameter int THR_64_6  = 60675
) (
   input logic          CLK_Demod,
   input logic          RST_Demod,
   demod_demapper_if.slave dm
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   // Magnitudes carry one extra bit so |-2^(W-1)| is representable.
   localparam logic [LUT_WIDTH:0] T_16   = (LUT_WIDTH+1)'(THR_16);
   localparam logic [LUT_WIDTH:0] T_64_2 = (LUT_WIDTH+1)'(THR_64_2);
   localparam logic [LUT_WIDTH:0] T_64_4 = (LUT_WIDTH+1)'(THR_64_4);
   localparam logic [LUT_WIDTH:0] T_64_6 = (LUT_WIDTH+1)'(THR_64_6);
   localparam logic [LUT_WIDTH:0] ONE    = (LUT_WIDTH+1)'(1);

   logic [0:0]  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [5:0]  sreg_q, sreg_d;
   logic        last_q, last_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [10:0] count_q, count_d;

   logic                 neg_i, neg_q;
   logic [LUT_WIDTH:0]   ext_i, ext_q, abs_i, abs_q;
   logic [5:0]           slice_bits;
   logic                 order_ok, ready, accept, emit, last_bit;

   // Slice the presented symbol; the result is only captured on accept.
   // Register layout is {b0,b1,b2,b3,b4,b5} so the MSB is always the next bit out.
   always_comb begin
      neg_i = dm.Demod_IN_I[LUT_WIDTH-1];
      neg_q = dm.Demod_IN_Q[LUT_WIDTH-1];
      ext_i = {neg_i, dm.Demod_IN_I};
      ext_q = {neg_q, dm.Demod_IN_Q};
      abs_i = neg_i ? (~ext_i + ONE) : ext_i;
      abs_q = neg_q ? (~ext_q + ONE) : ext_q;
      order_ok   = 1'b0;
      slice_bits = 6'b000000;
      case (dm.Order_Mod)
         3'd2: begin
            order_ok   = 1'b1;
            slice_bits = {neg_i, neg_q, 4'b0000};
         end
         3'd4: begin
            order_ok   = 1'b1;
            slice_bits = {neg_i, neg_q, (abs_i > T_16), (abs_q > T_16), 2'b00};
         end
         3'd6: begin
            order_ok   = 1'b1;
            slice_bits = {neg_i, neg_q, (abs_i > T_64_4), (abs_q > T_64_4),
                          (abs_i < T_64_2) | (abs_i > T_64_6),
                          (abs_q < T_64_2) | (abs_q > T_64_6)};
         end
         default: begin
            order_ok   = 1'b0;
            slice_bits = 6'b000000;
         end
      endcase
   end

   // Handshake and output decode; ready opens on the final bit so symbols chain gap-free.
   always_comb begin
      ready    = (state_q == IDLE) || (cnt_q == 3'd0);
      accept   = dm.EN_Demod && dm.Valid_Demod_IN && ready;
      emit     = (state_q == SHIFT) && dm.EN_Demod;
      last_bit = emit && (cnt_q == 3'd0) && last_q;
   end

   // Next-state: shift out, reload on accept, track block end and symbol count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sreg_d  = sreg_q;
      last_d  = last_q;
      done_d  = last_bit;
      err_d   = accept && !order_ok;
      count_d = (last_bit ? 11'd0 : count_q) + {10'd0, accept};
      if (emit) begin
         if (cnt_q != 3'd0) begin
            sreg_d = {sreg_q[4:0], 1'b0};
            cnt_d  = cnt_q - 3'd1;
         end else begin
            state_d = IDLE;
         end
      end
      if (accept && order_ok) begin
         state_d = SHIFT;
         sreg_d  = slice_bits;
         cnt_d   = dm.Order_Mod - 3'd1;
         last_d  = dm.Last_IN;
      end
   end

   // State registers; reset discards any partial symbol.
   always_ff @(posedge CLK_Demod or negedge RST_Demod) begin
      if (!RST_Demod) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         sreg_q  <= 6'b000000;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         count_q <= 11'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
         last_q  <= last_d;
         done_q  <= done_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

   // Drive the bus outputs.
   always_comb begin
      dm.Ready_Demod  = ready;
      dm.Serial_Valid = emit;
      dm.Serial_OUT   = emit && sreg_q[5];
      dm.Last_OUT     = last_bit;
      dm.DEMOD_DONE   = done_q;
      dm.Order_Err    = err_q;
      dm.Sym_Count    = count_q;
      dm.State_Dbg    = state_q;
   end

endmodule

// File: tb/tb_demod_demapper.sv
// Bench for demod_demapper: symbols come from a Gray mapper model or from raw
// random I/Q sliced by a threshold model; expected bits sit in a queue that
// drains one entry per enabled clock.
module tb_demod_demapper;
   localparam int W = 18;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // Clock and reset
   always #5 clk = ~clk;

   demod_demapper_if #(.LUT_WIDTH(W)) dif ();
   demod_demapper #(.LUT_WIDTH(W)) dut (
      .CLK_Demod (clk),
      .RST_Demod (rst_n),
      .dm        (dif)
   );

   // Scoreboard: entry = {last, bit}
   logic [1:0]  exp_q[$];
   logic [10:0] cnt_exp;
   logic        err_exp;
   logic        done_exp;
   logic [5:0]  exp_bits;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Spec-level slicer on plain integers
   function automatic logic [5:0] slice_ref(input int ord, input int i, input int q);
      int ai, aq;
      logic [5:0] b;
      ai = (i < 0) ? -i : i;
      aq = (q < 0) ? -q : q;
      b = 6'b000000;
      b[0] = (i < 0);
      b[1] = (q < 0);
      if (ord == 4) begin
         b[2] = (ai > 41449);
         b[3] = (aq > 41449);
      end else if (ord == 6) begin
         b[2] = (ai > 40450);
         b[3] = (aq > 40450);
         b[4] = (ai < 20225) || (ai > 60675);
         b[5] = (aq < 20225) || (aq > 60675);
      end else if (ord != 2) begin
         b = 6'b000000;
      end
      return b;
   endfunction

   // Gray mapper for one axis: s = sign bit, m/l = amplitude bits
   function automatic int axis(input int ord, input bit s, input bit m, input bit l);
      int a;
      int sm, sl;
      sm = m ? -1 : 1;
      sl = l ? -1 : 1;
      if (ord == 2)      a = 46341;
      else if (ord == 4) a = m ? 62173 : 20724;
      else               a = (4 - sm * (2 - sl)) * 10112;
      return s ? -a : a;
   endfunction

   // Reference model: pops one bit per enabled cycle, accepts when <=1 bit remains
   initial begin : model
      bit acc, popped_last;
      int n;
      cnt_exp = 11'd0; err_exp = 1'b0; done_exp = 1'b0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            exp_q.delete();
            cnt_exp = 11'd0; err_exp = 1'b0; done_exp = 1'b0;
         end else begin
            acc = dif.EN_Demod && dif.Valid_Demod_IN && (exp_q.size() <= 1);
            popped_last = 1'b0;
            if (dif.EN_Demod && exp_q.size() > 0) begin
               popped_last = exp_q[0][1];
               void'(exp_q.pop_front());
            end
            done_exp = popped_last;
            if (popped_last) cnt_exp = 11'd0;
            err_exp = 1'b0;
            if (acc) begin
               cnt_exp = cnt_exp + 11'd1;
               n = int'(dif.Order_Mod);
               if (n == 2 || n == 4 || n == 6) begin
                  for (int j = 0; j < n; j++)
                     exp_q.push_back({dif.Last_IN && (j == n - 1), exp_bits[j]});
               end else begin
                  err_exp = 1'b1;
               end
            end
         end
      end
   end

   // Compare process: every cycle on the falling edge
   initial begin : compare
      bit ev;
      forever begin
         @(negedge clk);
         ev = dif.EN_Demod && (exp_q.size() > 0);
         chk("ready", 32'(dif.Ready_Demod), 32'(exp_q.size() <= 1));
         chk("serial_valid", 32'(dif.Serial_Valid), 32'(ev));
         if (ev) chk("serial_out", 32'(dif.Serial_OUT), 32'(exp_q[0][0]));
         chk("last_out", 32'(dif.Last_OUT), 32'(ev ? exp_q[0][1] : 1'b0));
         chk("demod_done", 32'(dif.DEMOD_DONE), 32'(done_exp));
         chk("order_err", 32'(dif.Order_Err), 32'(err_exp));
         chk("sym_count", 32'(dif.Sym_Count), 32'(cnt_exp));
      end
   end

   // Driver tasks
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_sym(input logic [2:0] ord, input logic signed [W-1:0] i,
                           input logic signed [W-1:0] q, input logic last,
                           input logic [5:0] bits, input int en_pct);
      int guard;
      bit took;
      dif.Order_Mod = ord;
      dif.Demod_IN_I = i;
      dif.Demod_IN_Q = q;
      dif.Last_IN = last;
      exp_bits = bits;
      dif.Valid_Demod_IN = 1'b1;
      guard = 0;
      took = 1'b0;
      while (!took && guard < 200) begin
         dif.EN_Demod = ($urandom_range(99) < en_pct);
         took = dif.EN_Demod && (exp_q.size() <= 1);
         step(1);
         guard++;
      end
      if (!took) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=%0d expected=<200 t=%0t", guard, $time);
      end
      dif.Valid_Demod_IN = 1'b0;
      dif.EN_Demod = 1'b1;
   endtask

   task automatic mapped(input int ord, input logic [5:0] raw, input logic last, input int en_pct);
      logic [5:0] b;
      b = raw & 6'((1 << ord) - 1);
      send_sym(3'(ord), W'(axis(ord, b[0], b[2], b[4])), W'(axis(ord, b[1], b[3], b[5])),
               last, b, en_pct);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 100) begin
         step(1);
         guard++;
      end
      if (exp_q.size() > 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout actual=%0d expected=0 t=%0t", exp_q.size(), $time);
      end
   endtask

   // Watchdog
   initial begin
      #900000;
      $display("FAIL watchdog actual=running expected=finished t=%0t", $time);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

   // Stimulus
   initial begin : stim
      int ri, rq, ord;
      dif.EN_Demod = 1'b1;
      dif.Valid_Demod_IN = 1'b0;
      dif.Demod_IN_I = '0;
      dif.Demod_IN_Q = '0;
      dif.Last_IN = 1'b0;
      dif.Order_Mod = 3'd2;
      exp_bits = 6'b000000;
      step(3);
      @(negedge clk);
      chk("rst_ready", 32'(dif.Ready_Demod), 32'd1);
      chk("rst_count", 32'(dif.Sym_Count), 32'd0);
      rst_n = 1'b1;
      step(1);

      // Pin the models with hand-computed values
      chk("pin_qpsk", 32'(slice_ref(2, -46341, 46341)), 32'b000001);
      chk("pin_16qam", 32'(slice_ref(4, -62173, 20724)), 32'b000101);
      chk("pin_thr_eq", 32'(slice_ref(4, 41449, 0)), 32'b000000);
      chk("pin_thr_gt", 32'(slice_ref(4, 41450, 0)), 32'b000100);
      chk("pin_thr_min", 32'(slice_ref(4, -131072, 0)), 32'b000101);
      chk("pin_axis64", 32'(axis(6, 1'b1, 1'b1, 1'b1)), 32'(-70784));
      chk("pin_axis64b", 32'(axis(6, 1'b0, 1'b0, 1'b0)), 32'd30336);
      chk("pin_axis16", 32'(axis(4, 1'b1, 1'b1, 1'b0)), 32'(-62173));

      // QPSK latency
      send_sym(3'd2, -18'sd46341, 18'sd46341, 1'b0, slice_ref(2, -46341, 46341), 100);
      @(negedge clk);
      chk("qpsk_b0", 32'(dif.Serial_OUT), 32'd1);
      chk("qpsk_v0", 32'(dif.Serial_Valid), 32'd1);
      @(negedge clk);
      chk("qpsk_b1", 32'(dif.Serial_OUT), 32'd0);
      chk("qpsk_rdy", 32'(dif.Ready_Demod), 32'd1);
      @(negedge clk);
      chk("qpsk_end", 32'(dif.Serial_Valid), 32'd0);
      chk("cnt_1", 32'(dif.Sym_Count), 32'd1);
      step(1);

      // 16QAM back-to-back
      mapped(4, 6'b000000, 1'b0, 100);
      mapped(4, 6'b000101, 1'b0, 100);
      mapped(4, 6'b001010, 1'b0, 100);
      mapped(4, 6'b001111, 1'b0, 100);
      drain();
      step(1);
      chk("cnt_5", 32'(dif.Sym_Count), 32'd5);

      // Thresholds and extremes
      send_sym(3'd4, 18'sd41449, 18'sd0, 1'b0, slice_ref(4, 41449, 0), 100);
      send_sym(3'd4, 18'sd41450, 18'sd0, 1'b0, slice_ref(4, 41450, 0), 100);
      send_sym(3'd4, -18'sd131072, 18'sd0, 1'b0, slice_ref(4, -131072, 0), 100);
      drain();
      step(1);
      chk("cnt_8", 32'(dif.Sym_Count), 32'd8);

      // Invalid order then a valid one
      send_sym(3'd5, 18'sd1000, 18'sd1000, 1'b0, 6'b000000, 100);
      @(negedge clk);
      chk("err_pulse", 32'(dif.Order_Err), 32'd1);
      chk("err_novalid", 32'(dif.Serial_Valid), 32'd0);
      @(negedge clk);
      chk("err_once", 32'(dif.Order_Err), 32'd0);
      chk("cnt_9", 32'(dif.Sym_Count), 32'd9);
      step(1);
      mapped(2, 6'b000010, 1'b0, 100);
      drain();
      step(1);
      chk("cnt_10", 32'(dif.Sym_Count), 32'd10);

      // Block end on third 64QAM symbol
      mapped(6, 6'($urandom_range(63)), 1'b0, 100);
      mapped(6, 6'($urandom_range(63)), 1'b0, 100);
      mapped(6, 6'($urandom_range(63)), 1'b1, 100);
      drain();
      @(negedge clk);
      chk("done_pulse", 32'(dif.DEMOD_DONE), 32'd1);
      chk("done_count", 32'(dif.Sym_Count), 32'd0);
      step(1);

      // EN low for 3 cycles mid-symbol
      mapped(6, 6'b101101, 1'b0, 100);
      step(2);
      dif.EN_Demod = 1'b0;
      step(3);
      dif.EN_Demod = 1'b1;
      drain();
      step(1);

      // All 64 constellation points
      for (int p = 0; p < 64; p++) mapped(6, 6'(p), (p == 63), 100);
      drain();
      step(2);

      // 6000 random bits through the mapper, random EN and gaps
      for (int s = 0; s < 1000; s++) begin
         mapped(6, 6'($urandom_range(63)), ($urandom_range(49) == 0), 90);
         if ($urandom_range(9) == 0) step(1);
      end
      drain();
      step(2);

      // Mixed orders, raw I/Q, invalid codes
      for (int s = 0; s < 300; s++) begin
         ord = int'($urandom_range(7));
         if ((ord == 2 || ord == 4 || ord == 6) && $urandom_range(1) == 0) begin
            mapped(ord, 6'($urandom_range(63)), ($urandom_range(19) == 0), 90);
         end else begin
            ri = int'($urandom_range(262143)) - 131072;
            rq = int'($urandom_range(262143)) - 131072;
            send_sym(3'(ord), W'(ri), W'(rq), ($urandom_range(19) == 0),
                     slice_ref(ord, ri, rq), 90);
         end
      end
      drain();
      step(2);

      // Reset at bit 3 of a 64QAM symbol
      mapped(6, 6'b111111, 1'b0, 100);
      step(3);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 32'(dif.Serial_Valid), 32'd0);
      chk("mid_rst_out", 32'(dif.Serial_OUT), 32'd0);
      chk("mid_rst_cnt", 32'(dif.Sym_Count), 32'd0);
      step(1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(dif.Ready_Demod), 32'd1);
      step(1);
      mapped(2, 6'b000001, 1'b0, 100);
      drain();
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
